// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 message padder: FSM states,
// round count, length-counter width and the 0x80 pad word.
package sha1_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_PAD   = 2'd1,
    ST_LEN   = 2'd2,
    ST_ISSUE = 2'd3
  } state_t;

  localparam int ISSUE_ROUNDS = 81;
  localparam int LEN_W        = 64;
  localparam logic [31:0] PAD_WORD = 32'h8000_0000;

  // Keep the first nbytes of a big-endian word, put 0x80 right after them, zero the rest.
  function automatic logic [31:0] pad_last_word(input logic [31:0] data, input logic [2:0] nbytes);
    logic [31:0] w;
    case (nbytes)
      3'd0:    w = PAD_WORD;
      3'd1:    w = {data[31:24], 24'h80_0000};
      3'd2:    w = {data[31:16], 16'h8000};
      3'd3:    w = {data[31:8], 8'h80};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs 32-bit message words into 512-bit blocks, appends
// the 0x80 marker, zero fill and 64-bit bit length, and strobes each block into the core.
module sha1_padder #(
  parameter int ISSUE_ROUNDS = sha1_pkg::ISSUE_ROUNDS,
  parameter int LEN_W        = sha1_pkg::LEN_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic [2:0]  in_bytes,
  input  logic        in_last,
  output logic        in_ready,
  output logic        compute_enable,
  output logic [7:0]  round,
  output logic [31:0] input_data,
  output logic        block_first,
  output logic        block_last,
  output logic        busy
);
  import sha1_pkg::*;

  localparam logic [7:0] LAST_ROUND = 8'(ISSUE_ROUNDS);

  state_t      state;
  state_t      state_nxt;
  state_t      after_st;
  state_t      after_nxt;
  logic        pend80;
  logic        pend80_nxt;
  logic [3:0]  widx;
  logic [3:0]  widx_nxt;
  logic [LEN_W-1:0] bitlen;
  logic [63:0] len64;
  logic        first_armed;
  logic        accept;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        len_wr;
  logic        issue_enter;
  logic        issue_exit;
  logic [7:0]  round_nxt;
  logic        ce_nxt;
  logic [31:0] data_nxt;
  logic [31:0] blk_buf [16];

  assign in_ready    = (state == ST_FILL);
  assign accept      = in_valid && in_ready;
  assign len64       = 64'(bitlen);
  assign issue_enter = (state != ST_ISSUE) && (state_nxt == ST_ISSUE);
  assign issue_exit  = (state == ST_ISSUE) && (state_nxt != ST_ISSUE);

  // Next state, buffer write port and word index.
  // after_st remembers whether a non-final block interrupted filling or padding.
  always_comb begin
    state_nxt  = state;
    after_nxt  = after_st;
    pend80_nxt = pend80;
    widx_nxt   = widx;
    wr_en      = 1'b0;
    wr_data    = 32'h0000_0000;
    len_wr     = 1'b0;
    case (state)
      ST_FILL: begin
        if (accept) begin
          wr_en      = 1'b1;
          wr_data    = in_last ? pad_last_word(in_data, in_bytes) : in_data;
          widx_nxt   = widx + 4'd1;
          pend80_nxt = in_last && (in_bytes == 3'd4);
          if (widx == 4'd15) begin
            state_nxt = ST_ISSUE;
            after_nxt = in_last ? ST_PAD : ST_FILL;
          end else if (in_last) begin
            state_nxt = ((widx == 4'd13) && (in_bytes != 3'd4)) ? ST_LEN : ST_PAD;
          end else begin
            state_nxt = ST_FILL;
          end
        end else begin
          state_nxt = ST_FILL;
        end
      end
      ST_PAD: begin
        // A full final word defers its 0x80 marker to the first pad write.
        wr_en      = 1'b1;
        wr_data    = pend80 ? PAD_WORD : 32'h0000_0000;
        pend80_nxt = 1'b0;
        widx_nxt   = widx + 4'd1;
        if (widx == 4'd15) begin
          state_nxt = ST_ISSUE;
          after_nxt = ST_PAD;
        end else if (widx == 4'd13) begin
          state_nxt = ST_LEN;
        end else begin
          state_nxt = ST_PAD;
        end
      end
      ST_LEN: begin
        len_wr    = 1'b1;
        widx_nxt  = 4'd0;
        state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (round == LAST_ROUND) begin
          state_nxt = block_last ? ST_FILL : after_st;
        end else begin
          state_nxt = ST_ISSUE;
        end
      end
      default: begin
        state_nxt = ST_FILL;
      end
    endcase
  end

  // Round strobe outputs; the first ISSUE cycle only primes round 1.
  always_comb begin
    round_nxt = 8'd0;
    ce_nxt    = 1'b0;
    data_nxt  = 32'h0000_0000;
    if ((state == ST_ISSUE) && (round != LAST_ROUND)) begin
      round_nxt = round + 8'd1;
      ce_nxt    = 1'b1;
      if (round < 8'd16) begin
        data_nxt = blk_buf[round[3:0]];
      end else begin
        data_nxt = 32'h0000_0000;
      end
    end else begin
      round_nxt = 8'd0;
      ce_nxt    = 1'b0;
      data_nxt  = 32'h0000_0000;
    end
  end

  // FSM state, word index and round-output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_FILL;
      after_st       <= ST_FILL;
      pend80         <= 1'b0;
      widx           <= 4'd0;
      round          <= 8'd0;
      compute_enable <= 1'b0;
      input_data     <= 32'h0000_0000;
    end else begin
      state          <= state_nxt;
      after_st       <= after_nxt;
      pend80         <= pend80_nxt;
      widx           <= widx_nxt;
      round          <= round_nxt;
      compute_enable <= ce_nxt;
      input_data     <= data_nxt;
    end
  end

  // Message-level bookkeeping: bit length, busy and first/last block flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitlen      <= '0;
      busy        <= 1'b0;
      first_armed <= 1'b1;
      block_first <= 1'b0;
      block_last  <= 1'b0;
    end else begin
      if (accept) begin
        bitlen <= bitlen + LEN_W'({in_bytes, 3'b000});
        busy   <= 1'b1;
      end
      if (issue_enter) begin
        block_first <= first_armed;
        block_last  <= (state == ST_LEN);
      end else if (issue_exit) begin
        block_first <= 1'b0;
        block_last  <= 1'b0;
        first_armed <= block_last;
        if (block_last) begin
          busy   <= 1'b0;
          bitlen <= '0;
        end
      end
    end
  end

  // Block buffer; contents are irrelevant after reset, so it carries none.
  always_ff @(posedge clk) begin
    if (len_wr) begin
      blk_buf[14] <= len64[63:32];
      blk_buf[15] <= len64[31:0];
    end else if (wr_en) begin
      blk_buf[widx] <= wr_data;
    end
  end

endmodule
